// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pkg: shared types and word-address helpers for unified_mem_arbiter |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DATA  = 2'd1,
        ARB_FETCH = 2'd2
    } arb_state_t;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WORD_LSB = 2;
    localparam int TAG_W    = ADDR_W - WORD_LSB;

    function automatic logic [ADDR_W-1:0] word_to_byte(input logic [TAG_W-1:0] word);
        return {word, {WORD_LSB{1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/unified_mem_arbiter_fetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_buf: one-entry instruction buffer with hit compare, fill, invalidate |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_buf
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              inv_i,
    input  logic [TAG_W-1:0]  inv_tag_i,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
        end else if (inv_i && (inv_tag_i == tag_q)) begin
            // a store to the buffered word makes the copy stale
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unified_mem_arbiter: shares one single-port memory between fetch and data  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ACK_TIMEOUT = 255,
    parameter logic [31:0] ERR_DATA    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int WAIT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (ACK_TIMEOUT > 0) ? WAIT_W'(ACK_TIMEOUT - 1) : '0;

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [TAG_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_done_q, dm_done_d;
    logic              bus_err_q, bus_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              fb_hit;
    logic              fb_fill;
    logic              fb_inv;
    logic              timeout;
    logic              complete;
    logic [DATA_W-1:0] resp_data;
    logic              unused_lsbs;

    assign unused_lsbs = ^{if_addr[WORD_LSB-1:0], dm_addr[WORD_LSB-1:0]};

    fetch_buf u_fetch_buf (
        .clk          (clk),
        .reset        (reset),
        .fill_i       (fb_fill),
        .fill_tag_i   (mem_addr_q),
        .fill_data_i  (resp_data),
        .inv_i        (fb_inv),
        .inv_tag_i    (mem_addr_q),
        .lookup_tag_i (if_addr[ADDR_W-1:WORD_LSB]),
        .hit_o        (fb_hit),
        .data_o       (if_rdata)
    );

    // The timeout fires on the last allowed request cycle unless a real ack arrives
    generate
        if (ACK_TIMEOUT > 0) begin : g_timeout
            assign timeout = mem_req_q && !mem_ack && (wait_q == WAIT_LAST);
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign complete  = mem_req_q && (mem_ack || timeout);
    assign resp_data = mem_ack ? mem_rdata : ERR_DATA;
    assign if_stall  = !fb_hit;
    assign dm_stall  = dm_req && !dm_done_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dm_rdata_d  = dm_rdata_q;
        // M advances on every edge without a stall, which retires the done flag
        dm_done_d   = dm_stall ? dm_done_q : 1'b0;
        bus_err_d   = bus_err_q | timeout;
        wait_d      = '0;
        fb_fill     = 1'b0;
        fb_inv      = 1'b0;

        if (mem_req_q && !complete) begin
            wait_d = (ACK_TIMEOUT > 0) ? wait_q + 1'b1 : '0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (dm_req && !dm_done_q) begin
                    state_d     = ARB_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr[ADDR_W-1:WORD_LSB];
                    mem_wdata_d = dm_wdata;
                end else if (!fb_hit) begin
                    state_d    = ARB_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr[ADDR_W-1:WORD_LSB];
                end
            end
            ARB_DATA: begin
                if (complete) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    dm_done_d = 1'b1;
                    fb_inv    = mem_we_q;
                    if (!mem_we_q) begin
                        dm_rdata_d = resp_data;
                    end
                end
            end
            ARB_FETCH: begin
                if (complete) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    fb_fill   = 1'b1;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dm_rdata_q  <= '0;
            dm_done_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_done_q   <= dm_done_d;
            bus_err_q   <= bus_err_d;
            wait_q      <= wait_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = word_to_byte(mem_addr_q);
    assign mem_wdata = mem_wdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_unified_mem_arbiter: directed tables, corner sequences, random pipeline |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    unified_mem_arbiter #(.ACK_TIMEOUT(4), .ERR_DATA(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 0)  return 32'h2008_0005;
        if (i == 16) return 32'h0000_1234;
        return 32'hA500_0000 | 32'(i << 8) | 32'(i);
    endfunction

    // Memory model: ack in the (mw+1)th request cycle, contents restored on reset
    logic [31:0] mem [0:255];
    int          mw = 0;
    bit          noack = 1'b0;
    int          cnt;

    assign mem_ack   = mem_req && !noack && (cnt == mw);
    assign mem_rdata = mem_ack ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_req) begin
            if (mem_ack) begin
                cnt <= 0;
                if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    logic [31:0] ref_mem [0:255];

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    endtask

    // Issue one M-stage access and measure stall cycles and request cycles
    task automatic data_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output int st, output int rq, output int bad);
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        st = 0; rq = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_req) begin
                rq++;
                if (mem_we !== we || mem_addr !== {a[31:2], 2'b00} || (we && mem_wdata !== wd))
                    bad++;
            end
            if (!dm_stall) break;
            st++;
        end
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    logic        lg_req [0:15];
    logic        lg_we  [0:15];
    logic [31:0] lg_addr[0:15];
    logic        lg_ifs [0:15];

    task automatic run_log(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            lg_req[k] = mem_req; lg_we[k] = mem_we; lg_addr[k] = mem_addr; lg_ifs[k] = if_stall;
            if (dm_req && !dm_stall) begin
                @(posedge clk); #1;
                dm_req = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          w;
        int          exp_stall;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [0:5];

    initial begin : main
        int c, st, rq, bad, ifs_cnt, retires, fetches, first_set;
        logic        prev_req, prev_done, prev_we;
        logic [31:0] prev_addr, prev_wdata, first_addr;
        logic        first_we, adv_m, adv_f;

        tbl[0] = '{1'b0, 32'h0000_0040, 32'h0,          3, 5, 32'h0000_1234};
        tbl[1] = '{1'b0, 32'h0000_0046, 32'h0,          0, 2, init_word(17)};
        tbl[2] = '{1'b1, 32'h0000_0080, 32'h1111_2222,  1, 3, init_word(17)};
        tbl[3] = '{1'b0, 32'h0000_0081, 32'h0,          2, 4, 32'h1111_2222};
        tbl[4] = '{1'b1, 32'h0000_00C4, 32'h0BAD_F00D,  0, 2, 32'h1111_2222};
        tbl[5] = '{1'b0, 32'h0000_00C7, 32'h0,          1, 3, 32'h0BAD_F00D};

        // Reset release and first fetch of address 0
        mw = 0;
        do_reset();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_if_stall", 32'(if_stall), 32'd1);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        c = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!if_stall) break;
            c++;
        end
        chk("boot_fetch_stall", 32'(c), 32'd2);
        chk("boot_if_rdata", if_rdata, 32'h2008_0005);
        rq = 0;
        repeat (6) begin @(negedge clk); if (mem_req) rq++; end
        chk("boot_no_refetch", 32'(rq), 32'd0);

        // Table of isolated data accesses with the fetch buffer hitting
        for (int i = 0; i < 6; i++) begin
            mw = tbl[i].w;
            data_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, st, rq, bad);
            chk($sformatf("vec%0d_stall", i), 32'(st), 32'(tbl[i].exp_stall));
            chk($sformatf("vec%0d_rdata", i), dm_rdata, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_req_fields", i), 32'(bad), 32'd0);
            chk($sformatf("vec%0d_req_cycles", i), 32'(rq), 32'(tbl[i].w + 1));
        end

        // Fetch miss at 0x8 coincident with a store to 0x100
        @(posedge clk); #1;
        mw = 0;
        if_addr = 32'h8; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hCAFE_F00D;
        run_log(8);
        ifs_cnt = 0;
        for (int k = 0; k < 8; k++) if (lg_ifs[k]) ifs_cnt++;
        chk("coinc_first_req", 32'(lg_req[1]), 32'd1);
        chk("coinc_first_we", 32'(lg_we[1]), 32'd1);
        chk("coinc_first_addr", lg_addr[1], 32'h100);
        chk("coinc_idle_gap", 32'(lg_req[2]), 32'd0);
        chk("coinc_fetch_req", 32'(lg_req[3]), 32'd1);
        chk("coinc_fetch_we", 32'(lg_we[3]), 32'd0);
        chk("coinc_fetch_addr", lg_addr[3], 32'h8);
        chk("coinc_if_stall_cycles", 32'(ifs_cnt), 32'd4);
        chk("coinc_if_rdata", if_rdata, init_word(2));

        // Store to the buffered word forces a refetch
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8; dm_wdata = 32'h1357_2468;
        run_log(8);
        chk("coh_hit_before", 32'(lg_ifs[0]), 32'd0);
        chk("coh_stall_rises", 32'(lg_ifs[2]), 32'd1);
        chk("coh_refetch_req", 32'(lg_req[3]), 32'd1);
        chk("coh_refetch_addr", lg_addr[3], 32'h8);
        chk("coh_refetch_we", 32'(lg_we[3]), 32'd0);
        chk("coh_new_data", if_rdata, 32'h1357_2468);
        chk("coh_if_stall_end", 32'(if_stall), 32'd0);

        // Randomized pipeline traffic against a word-array reference
        do_reset();
        prev_req = 1'b0; prev_done = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
        retires = 0; fetches = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (prev_done)
                chk("rnd_req_drop", 32'(mem_req), 32'd0);
            else if (prev_req && mem_req)
                chk("rnd_req_stable",
                    32'(mem_we == prev_we && mem_addr == prev_addr && mem_wdata == prev_wdata), 32'd1);
            adv_m = !dm_stall;
            adv_f = !dm_stall && !if_stall;
            if (dm_req && !dm_stall) begin
                if (dm_we) ref_mem[dm_addr[9:2]] = dm_wdata;
                else chk("rnd_load", dm_rdata, ref_mem[dm_addr[9:2]]);
                retires++;
            end
            if (!if_stall) chk("rnd_fetch", if_rdata, ref_mem[if_addr[9:2]]);
            if (adv_f) fetches++;
            prev_req = mem_req; prev_done = mem_req && mem_ack;
            prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
            @(posedge clk); #1;
            if (cnt == 0) mw = $urandom_range(0, 3);
            if (adv_m) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = {24'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00} >> 2;
                dm_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                dm_wdata = $urandom;
            end
            if (adv_f) begin
                if ($urandom_range(0, 1) == 0)
                    if_addr = {26'h0, 4'(if_addr[5:2] + 4'd1), 2'($urandom_range(0, 3))};
                else
                    if_addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            end
        end
        chk("rnd_retires", 32'(retires > 100), 32'd1);
        chk("rnd_fetches", 32'(fetches > 100), 32'd1);
        chk("rnd_no_bus_err", 32'(bus_err), 32'd0);

        // Timeout on a load that is never acknowledged
        do_reset();
        mw = 0;
        repeat (4) @(posedge clk);
        data_op(1'b0, 32'h40, 32'h0, st, rq, bad);
        chk("to_pre_rdata", dm_rdata, 32'h0000_1234);
        chk("to_pre_bus_err", 32'(bus_err), 32'd0);
        noack = 1'b1;
        data_op(1'b0, 32'h40, 32'h0, st, rq, bad);
        chk("to_req_cycles", 32'(rq), 32'd4);
        chk("to_rdata", dm_rdata, 32'h0000_0000);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        noack = 1'b0;
        repeat (5) @(negedge clk);
        chk("to_bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset in the second cycle of a DATA transaction
        mw = 3;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'h7777_7777;
        @(posedge clk);
        @(posedge clk); #1;
        chk("ar_pre_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_mem_req", 32'(mem_req), 32'd0);
        chk("ar_mem_we", 32'(mem_we), 32'd0);
        chk("ar_mem_addr", mem_addr, 32'd0);
        chk("ar_mem_wdata", mem_wdata, 32'd0);
        chk("ar_dm_rdata", dm_rdata, 32'd0);
        chk("ar_if_stall", 32'(if_stall), 32'd1);
        chk("ar_if_rdata", if_rdata, 32'd0);
        chk("ar_bus_err", 32'(bus_err), 32'd0);
        dm_req = 1'b0; dm_we = 1'b0; if_addr = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        c = 0; first_set = 0; first_addr = 32'hFFFF_FFFF; first_we = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mem_req && first_set == 0) begin
                first_set = 1; first_addr = mem_addr; first_we = mem_we;
            end
            if (!if_stall) break;
            c++;
        end
        chk("ar_restart_stall", 32'(c), 32'd5);
        chk("ar_restart_addr", first_addr, 32'd0);
        chk("ar_restart_we", 32'(first_we), 32'd0);
        chk("ar_restart_data", if_rdata, 32'h2008_0005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port, word-wide external memory between the pipeline's instruction fetch (F stage) and data access (M stage). Sequences every memory transaction with a req/ack handshake and holds a one-entry fetch buffer. Generates the stall signals that freeze the pipeline while either side waits. Sits between `pipeline_proc` and the memory model: `if_stall` ORs into `stallf`/`stalld`, and `~dm_stall` drives the pipeline `enable`.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255: maximum number of cycles `mem_req` is held without `mem_ack`. 0 disables the timeout.
- `ERR_DATA`, default 32'h0000_0000: read data returned on a timed-out transaction.

Ports (reset `reset`, asynchronous, active-high; clock `clk`):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `if_addr` in 32: fetch address (`pcf`).
- `if_rdata` out 32: instruction (`instrf`).
- `if_stall` out 1: fetch not yet satisfied.
- `dm_req` in 1: M stage needs memory (`memwritem | memtoregm`).
- `dm_we` in 1: store.
- `dm_addr` in 32: data address (`aluoutm`).
- `dm_wdata` in 32: store data (`writedatam`).
- `dm_rdata` out 32: load data (`readdatam`).
- `dm_stall` out 1: global pipeline freeze.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: memory request.
- `mem_rdata` in 32, `mem_ack` in 1: memory response.
- `bus_err` out 1: sticky timeout flag.

## Operation
- States are IDLE, DATA and FETCH. Transactions are never preempted.
- Addresses are word-granular. Comparisons use [31:2], and `mem_addr` = {addr[31:2], 2'b00}.
- Fetch buffer fields: `fb_valid`, `fb_addr[31:2]`, `fb_data`.
  - Hit = `fb_valid & fb_addr == if_addr[31:2]`.
  - `if_stall = ~hit` (combinational).
  - `if_rdata = fb_data`.
- `dm_done` flag:
  - Set on completion of a DATA transaction.
  - Cleared at every edge where `dm_stall` = 0, because M advances at that edge.
  - `dm_stall = dm_req & ~dm_done` (combinational).
- IDLE transitions:
  - If `dm_req & ~dm_done`: go to DATA and latch `dm_we`/`dm_addr`/`dm_wdata` into the `mem_*` registers. Data has priority.
  - Else if fetch miss: go to FETCH, latch `if_addr`, `mem_we` = 0.
  - Else stay in IDLE.
- DATA/FETCH:
  - `mem_req` = 1, with all `mem_*` held stable.
  - On an edge with `mem_ack` = 1: return to IDLE and drop `mem_req`.
    - DATA: `dm_rdata` ← `mem_rdata` for loads only, and `dm_done` ← 1.
    - FETCH: `fb_data` ← `mem_rdata`, `fb_addr` ← latched address, `fb_valid` ← 1.
- Timeout (`ACK_TIMEOUT` > 0):
  - A wait counter of width $clog2(ACK_TIMEOUT+1) counts request cycles without ack.
  - When it reaches `ACK_TIMEOUT`, the transaction completes as if acked, with data = `ERR_DATA`.
  - `bus_err` ← 1 and remains set until reset.
- Coherence: a completed store with `dm_addr[31:2] == fb_addr` clears `fb_valid`, forcing a refetch.
- A fetch whose latched address no longer matches `if_addr` at completion still fills the buffer. The next cycle then misses and refetches.
- `mem_ack` while `mem_req` = 0 is ignored.

## Timing
- Reset values:
  - `mem_req`/`mem_we` = 0; `mem_addr`/`mem_wdata` = 0; `dm_rdata` = 0; `fb_data` = 0.
  - `fb_valid` = 0, so `if_stall` = 1 immediately after reset.
  - `dm_done` = 0, `bus_err` = 0, state = IDLE, wait counter = 0.
- Reset mid-transaction aborts immediately. `mem_req` falls asynchronously, and the memory tolerates the abandoned request.
- `mem_*` outputs are registered. `mem_req` rises the edge after the request is seen in IDLE.
- Latency, with W memory wait cycles (ack in the (W+1)th request cycle):
  - Data stall = W+2 cycles.
  - Fetch miss stall = W+2 cycles when no data request is pending.
- There is at least one IDLE cycle between consecutive transactions; `mem_req` is low for at least one cycle.
- Simultaneous data request and fetch miss: data transaction first, then the fetch. With W=0, `if_stall` lasts 4 cycles.

## Structure
- Package `mem_arb_pkg` contains:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_DATA, ARB_FETCH} arb_state_t`.
  - The word-address slice helper constants (WORD_LSB = 2).
- Sub-module `fetch_buf` holds valid/tag/data and performs hit compare, fill and invalidate.
- The FSM, wait counter and `dm_done` live in the top module.

## Test plan
- Reset release; memory at 0x0 holds 0x20080005; W=0:
  - `if_stall` = 1 for 2 cycles.
  - Then `if_rdata` = 0x20080005 and `if_stall` = 0.
  - No further `mem_req` while `if_addr` stays at 0x0.
- Load with `dm_req`=1, `dm_we`=0, `dm_addr`=0x40, memory returns 0x00001234, W=3:
  - `dm_stall` high for exactly 5 cycles.
  - Then `dm_rdata` = 0x00001234.
  - No fetch is issued during the load.
- Fetch miss at 0x8 coincident with store of 0xCAFEF00D to 0x100, W=0:
  - First `mem_req` has `mem_we`=1 and `mem_addr`=0x100.
  - After one idle cycle, a fetch of 0x8 is issued.
- Buffered fetch at 0x8, then store to 0x8:
  - `fb_valid` clears and `if_stall` rises.
  - A refetch of 0x8 is observed, returning the new data.
- `ACK_TIMEOUT`=4, memory never acks a load:
  - `mem_req` high for exactly 4 cycles.
  - `dm_rdata` = 0x00000000 and `bus_err` = 1, which persists until reset.
- Reset asserted in the second cycle of a DATA transaction:
  - `mem_req` = 0 in the same cycle.
  - All outputs at their reset values.
  - After release, the fetch of address 0 restarts.
